// File: rtl/fifo_spram_pkg.sv
// rtl/fifo_spram_pkg.sv - shared defaults, bank command type and output-queue sizing for the SPRAM FIFO
package fifo_spram_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_RD_LAT     = 2;
    localparam int DEF_ADDR_WIDTH = $clog2(DEF_FIFO_DEPTH);

    typedef struct packed {
        logic                      wen;
        logic [DEF_DATA_WIDTH-1:0] wdata;
        logic [DEF_ADDR_WIDTH-1:0] waddr;
        logic                      ren;
        logic [DEF_ADDR_WIDTH-1:0] raddr;
    } bank_cmd_t;

    // Two spare slots beyond the read latency keep a full-rate read stream from stalling.
    function automatic int outq_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

endpackage

// File: rtl/fifo_spram_outq.sv
// rtl/fifo_spram_outq.sv - first-word-fall-through output queue absorbing bank read latency
module fifo_spram_outq #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic [CW-1:0]         count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic                  do_push;
    logic                  do_pop;

    assign valid   = (count != '0);
    assign do_pop  = pop & valid;
    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
    assign data    = mem[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[tail] <= push_data;
                tail      <= (tail == LAST) ? '0 : tail + 1'b1;
            end
            if (do_pop) begin
                head <= (head == LAST) ? '0 : head + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    outq_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !do_push));

endmodule

// File: rtl/fifo_spram_ctrl.sv
// rtl/fifo_spram_ctrl.sv - streaming FIFO control for a single-port-RAM bank; FIFO_SPRAM_COUNT_EN adds a count port
module fifo_spram_ctrl
    import fifo_spram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int OUTQ_DEPTH = outq_depth(RD_LAT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  bank_wen,
    output logic [DATA_WIDTH-1:0] bank_wdata,
    output logic [ADDR_WIDTH-1:0] bank_waddr,
    output logic                  bank_ren,
    output logic [ADDR_WIDTH-1:0] bank_raddr,
    input  logic [DATA_WIDTH-1:0] bank_rdata,
    output logic                  full,
    output logic                  empty
`ifdef FIFO_SPRAM_COUNT_EN
    ,
    output logic [$clog2(FIFO_DEPTH+OUTQ_DEPTH+1)-1:0] count
`endif
);
    localparam int MW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(OUTQ_DEPTH + 1);
    localparam logic [MW-1:0] MEM_FULL   = MW'(FIFO_DEPTH);
    localparam logic [CW:0]   CREDIT_LIM = (CW + 1)'(OUTQ_DEPTH);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [MW-1:0]         mem_count;
    logic [MW-1:0]         mem_count_nxt;
    logic                  bubble;
    logic [RD_LAT:1]       infl;
    logic [CW-1:0]         inflight_cnt;
    logic [CW-1:0]         outq_cnt;
    logic [CW:0]           credit_used;
    logic                  wr;
    logic                  rd;
    logic                  pop;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 1; i <= RD_LAT; i++) begin
            inflight_cnt = inflight_cnt + CW'(infl[i]);
        end
    end

    // Reads are only issued when a landing slot in the output queue is already reserved.
    assign credit_used   = {1'b0, inflight_cnt} + {1'b0, outq_cnt};
    assign s_ready       = ~bubble & (mem_count != MEM_FULL);
    assign wr            = s_valid & s_ready;
    assign rd            = (mem_count != '0) & ~bubble & (credit_used < CREDIT_LIM);
    assign mem_count_nxt = mem_count + MW'(wr) - MW'(rd);
    assign pop           = m_valid & m_ready;

    assign bank_wen   = wr;
    assign bank_wdata = s_data;
    assign bank_waddr = wptr;
    assign bank_ren   = rd;
    assign bank_raddr = rptr;

    assign full  = (mem_count == MEM_FULL);
    assign empty = (mem_count == '0) & (infl == '0) & (outq_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            mem_count <= '0;
            bubble    <= 1'b0;
            infl      <= '0;
        end else begin
            wptr      <= wptr + ADDR_WIDTH'(wr);
            rptr      <= rptr + ADDR_WIDTH'(rd);
            mem_count <= mem_count_nxt;
            // The bank defers a colliding write into the following cycle, so that cycle stays idle.
            bubble    <= wr & rd;
            infl[1]   <= rd;
            for (int i = 2; i <= RD_LAT; i++) begin
                infl[i] <= infl[i-1];
            end
        end
    end

    fifo_spram_outq #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OUTQ_DEPTH),
        .CW         (CW)
    ) u_outq (
        .clk       (clk),
        .rst       (rst),
        .push      (infl[RD_LAT]),
        .push_data (bank_rdata),
        .pop       (pop),
        .data      (m_data),
        .valid     (m_valid),
        .count     (outq_cnt)
    );

`ifdef FIFO_SPRAM_COUNT_EN
    localparam int KW = $clog2(FIFO_DEPTH + OUTQ_DEPTH + 1);

    // Next-cycle total: the in-flight push moves a word from pipe to queue, so it cancels out.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= KW'(mem_count_nxt) + KW'(inflight_cnt) + KW'(outq_cnt) + KW'(rd) - KW'(pop);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_spram_ctrl.sv
// tb/tb_fifo_spram_ctrl.sv - directed and scoreboard bench for fifo_spram_ctrl with a two-stage bank model
module tb_fifo_spram_ctrl;
    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, m_valid, m_ready;
    logic [DW-1:0] s_data, m_data;
    logic          bank_wen, bank_ren, full, empty;
    logic [DW-1:0] bank_wdata, bank_rdata;
    logic [AW-1:0] bank_waddr, bank_raddr;
`ifdef FIFO_SPRAM_COUNT_EN
    logic [$clog2(DEPTH+4+1)-1:0] count;
`endif

    always #5 clk = ~clk;

    fifo_spram_ctrl dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .bank_wen(bank_wen), .bank_wdata(bank_wdata), .bank_waddr(bank_waddr),
        .bank_ren(bank_ren), .bank_raddr(bank_raddr), .bank_rdata(bank_rdata),
        .full(full), .empty(empty)
`ifdef FIFO_SPRAM_COUNT_EN
        , .count(count)
`endif
    );

    // Bank: registered read data two cycles after the read command; pipe keeps running through rst.
    logic [DW-1:0] bmem [DEPTH];
    logic [DW-1:0] bst1;
    always_ff @(posedge clk) begin
        if (bank_wen) bmem[bank_waddr] <= bank_wdata;
        bst1       <= bmem[bank_raddr];
        bank_rdata <= bst1;
    end

    int total = 0;
    int bad = 0;
    int nacc, outstanding, bub_err, credit_err, wen_err;
    logic prev_collide;
    logic [DW-1:0] sb[$];

    typedef struct {
        logic          sv;
        logic [DW-1:0] sd;
        logic [5:0]    flags;   // s_ready, bank_wen, bank_ren, m_valid, empty, full
        logic [DW-1:0] md;
    } vec_t;
    vec_t vt[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sample();
        #1;
        if (prev_collide && (bank_wen || bank_ren)) bub_err++;
        prev_collide = bank_wen && bank_ren;
        if (bank_wen !== (s_valid && s_ready)) wen_err++;
        if (bank_ren) outstanding++;
        if (m_valid && m_ready) begin
            outstanding--;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_pop actual=%0h required=none", m_data);
            end else begin
                check("m_data", {24'd0, m_data}, {24'd0, sb.pop_front()});
            end
        end
        if (s_valid && s_ready) begin
            sb.push_back(s_data);
            nacc++;
        end
        if (outstanding > 4) credit_err++;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        advance();
        rst = 1'b0;
        sb.delete(); outstanding = 0; prev_collide = 1'b0; nacc = 0;
        #1;
        check("rst_flags", {26'd0, s_ready, m_valid, bank_wen, bank_ren, full, empty}, 32'b100001);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        advance();
    endtask

    task automatic drain(input string name);
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0 && outstanding == 0) break;
            sample();
            advance();
        end
        check(name, sb.size(), 32'd0);
        check({name, "_empty"}, {31'd0, empty}, 32'd1);
    endtask

    initial begin
        logic done16, hit;
        int   stale;
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        bub_err = 0; credit_err = 0; wen_err = 0;
        //          sv    sd     sr wen ren mv emp full   md
        vt[0] = '{1'b1, 8'h11, 6'b110010, 8'h00};
        vt[1] = '{1'b1, 8'h22, 6'b111000, 8'h00};
        vt[2] = '{1'b1, 8'h33, 6'b000000, 8'h00};
        vt[3] = '{1'b1, 8'h33, 6'b111000, 8'h00};
        vt[4] = '{1'b0, 8'h00, 6'b000100, 8'h11};
        vt[5] = '{1'b0, 8'h00, 6'b101000, 8'h00};
        vt[6] = '{1'b0, 8'h00, 6'b100100, 8'h22};
        vt[7] = '{1'b0, 8'h00, 6'b100000, 8'h00};
        vt[8] = '{1'b0, 8'h00, 6'b100100, 8'h33};
        vt[9] = '{1'b0, 8'h00, 6'b100010, 8'h00};
        @(negedge clk);

        // Three words with the collision bubbles, first m_valid four cycles after accept
        do_reset();
        for (int i = 0; i < 10; i++) begin
            s_valid = vt[i].sv; s_data = vt[i].sd; m_ready = 1'b1;
            sample();
            check($sformatf("vec%0d_flags", i),
                  {26'd0, s_ready, bank_wen, bank_ren, m_valid, empty, full}, {26'd0, vt[i].flags});
            if (vt[i].flags[2]) check($sformatf("vec%0d_data", i), {24'd0, m_data}, {24'd0, vt[i].md});
            advance();
        end

        // Fill with the sink stalled: four words prefetched, full after twenty accepts
        do_reset();
        done16 = 1'b0;
        for (int i = 0; i < 200 && nacc < 20; i++) begin
            s_valid = 1'b1; s_data = nacc[7:0];
            if (nacc == 16 && !done16) begin
                check("not_full_at_16", {31'd0, full}, 32'd0);
                done16 = 1'b1;
            end
            sample();
            advance();
        end
        check("fill_count", nacc, 32'd20);
        s_valid = 1'b0;
        check("fill_flags", {29'd0, full, s_ready, m_valid}, 32'b101);
        drain("fill_drain");

        // Both sides streaming across the pointer wrap
        do_reset();
        for (int i = 0; i < 400 && nacc < 40; i++) begin
            s_valid = 1'b1; m_ready = 1'b1; s_data = 8'(nacc * 7 + 3);
            sample();
            advance();
        end
        check("stream_count", nacc, 32'd40);
        drain("stream_drain");

        // Random valid/ready traffic
        do_reset();
        for (int i = 0; i < 20000 && nacc < 1000; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom_range(0, 255));
            sample();
            advance();
        end
        check("rand_count", nacc, 32'd1000);
        drain("rand_drain");

        // Reset while reads are in flight: stale bank data must not surface
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            s_valid = 1'b1; m_ready = 1'b0; s_data = 8'(8'hA0 + i);
            sample();
            hit = (nacc >= 3) && bank_ren;
            advance();
            if (hit) break;
        end
        check("mid_inflight", {31'd0, hit}, 32'd1);
        do_reset();
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b0; m_ready = 1'b1;
            sample();
            if (m_valid) stale++;
            advance();
        end
        check("stale_after_rst", stale, 32'd0);
        for (int i = 0; i < 10 && nacc < 1; i++) begin
            s_valid = 1'b1; s_data = 8'h5A; m_ready = 1'b1;
            sample();
            advance();
        end
        check("post_rst_accept", nacc, 32'd1);
        drain("post_rst_drain");

        check("bubble_rule", bub_err, 32'd0);
        check("credit_limit", credit_err, 32'd0);
        check("wen_handshake", wen_err, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
